// File: rtl/axis_rr_merge.sv
// ---------------------------------------------------------------------------
// axis_rr_merge
//   Round-robin merge of two AXI-Stream sources (A, B) into one output stream.
//   A grant lasts up to MAX_BURST beats. After that, the grant passes to the
//   other source if it is requesting. When both sources request from IDLE,
//   the source that was not served last wins. The output is a single
//   registered slot. Narrower source data is placed in the MSBs of the
//   output word, and the LSBs are zero-filled.
//
// Ports
//   a_clk, a_reset         : clock, synchronous active-high reset
//   enable                 : permits grants; low forces IDLE and drops tready
//   S_AXIS_A_* / S_AXIS_B_*: source streams (tdata, tvalid, tready)
//   M_AXIS_*               : merged stream (tdata, tvalid, tready)
//   M_AXIS_tuser           : source of current output beat (0 = A, 1 = B)
//   monitor                : {beats_b[15:0], beats_a[15:0]} transfer counters
//
// MAXIS_TDATA_WIDTH must be >= SAXIS_TDATA_WIDTH; MAX_BURST in 1..255.
// ---------------------------------------------------------------------------
module axis_rr_merge #(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int MAX_BURST         = 4
) (
    input  logic                         a_clk,
    input  logic                         a_reset,
    input  logic                         enable,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_A_tdata,
    input  logic                         S_AXIS_A_tvalid,
    output logic                         S_AXIS_A_tready,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_B_tdata,
    input  logic                         S_AXIS_B_tvalid,
    output logic                         S_AXIS_B_tready,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic                         M_AXIS_tuser,
    output logic [31:0]                  monitor
);

    localparam int PAD = MAXIS_TDATA_WIDTH - SAXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t                         r_state;
    logic                           r_last_b;      // last_served: 0 = A, 1 = B
    logic [7:0]                     r_burst_cnt;
    logic                           r_m_tvalid;
    logic                           r_m_tuser;
    logic [MAXIS_TDATA_WIDTH-1:0]   r_m_tdata;
    logic [15:0]                    r_beats_a;
    logic [15:0]                    r_beats_b;

    logic                           w_slot_free;
    logic                           w_a_ready;
    logic                           w_b_ready;
    logic                           w_a_xfer;
    logic                           w_b_xfer;
    logic [7:0]                     w_cnt_inc;
    logic                           w_burst_done;
    logic [MAXIS_TDATA_WIDTH-1:0]   w_a_ext;
    logic [MAXIS_TDATA_WIDTH-1:0]   w_b_ext;

    assign w_slot_free = !r_m_tvalid || M_AXIS_tready;

    // Reset is folded into tready so no source beat is accepted in the reset cycle.
    assign w_a_ready = (r_state == GRANT_A) && enable && w_slot_free && !a_reset;
    assign w_b_ready = (r_state == GRANT_B) && enable && w_slot_free && !a_reset;

    assign w_a_xfer = S_AXIS_A_tvalid && w_a_ready;
    assign w_b_xfer = S_AXIS_B_tvalid && w_b_ready;

    assign w_cnt_inc    = r_burst_cnt + 8'd1;
    assign w_burst_done = (w_cnt_inc == 8'(MAX_BURST));

    // Source data goes to the MSBs; the shift zero-fills the LSBs.
    assign w_a_ext = MAXIS_TDATA_WIDTH'(S_AXIS_A_tdata) << PAD;
    assign w_b_ext = MAXIS_TDATA_WIDTH'(S_AXIS_B_tdata) << PAD;

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            r_state     <= IDLE;
            r_last_b    <= 1'b1;
            r_burst_cnt <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_m_tdata   <= '0;
            r_beats_a   <= '0;
            r_beats_b   <= '0;
        end else begin
            // Output slot: load on a transfer, otherwise drain when accepted.
            if (w_a_xfer) begin
                r_m_tdata  <= w_a_ext;
                r_m_tuser  <= 1'b0;
                r_m_tvalid <= 1'b1;
            end else if (w_b_xfer) begin
                r_m_tdata  <= w_b_ext;
                r_m_tuser  <= 1'b1;
                r_m_tvalid <= 1'b1;
            end else if (M_AXIS_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_a_xfer) r_beats_a <= r_beats_a + 16'd1;
            if (w_b_xfer) r_beats_b <= r_beats_b + 16'd1;

            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (S_AXIS_A_tvalid && (!S_AXIS_B_tvalid || r_last_b)) begin
                            r_state     <= GRANT_A;
                            r_burst_cnt <= '0;
                        end else if (S_AXIS_B_tvalid) begin
                            r_state     <= GRANT_B;
                            r_burst_cnt <= '0;
                        end
                    end
                    GRANT_A: begin
                        if (w_a_xfer) begin
                            r_last_b <= 1'b0;
                            if (w_burst_done) begin
                                r_burst_cnt <= '0;
                                if (S_AXIS_B_tvalid) r_state <= GRANT_B;
                            end else begin
                                r_burst_cnt <= w_cnt_inc;
                            end
                        end else if (!S_AXIS_A_tvalid) begin
                            r_burst_cnt <= '0;
                            r_state     <= S_AXIS_B_tvalid ? GRANT_B : IDLE;
                        end
                        // tvalid high but slot busy: hold state and counter.
                    end
                    GRANT_B: begin
                        if (w_b_xfer) begin
                            r_last_b <= 1'b1;
                            if (w_burst_done) begin
                                r_burst_cnt <= '0;
                                if (S_AXIS_A_tvalid) r_state <= GRANT_A;
                            end else begin
                                r_burst_cnt <= w_cnt_inc;
                            end
                        end else if (!S_AXIS_B_tvalid) begin
                            r_burst_cnt <= '0;
                            r_state     <= S_AXIS_A_tvalid ? GRANT_A : IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign S_AXIS_A_tready = w_a_ready;
    assign S_AXIS_B_tready = w_b_ready;
    assign M_AXIS_tdata    = r_m_tdata;
    assign M_AXIS_tvalid   = r_m_tvalid;
    assign M_AXIS_tuser    = r_m_tuser;
    assign monitor         = {r_beats_b, r_beats_a};

endmodule

// File: tb/tb_axis_rr_merge.sv
module tb_axis_rr_merge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 32 -> 32, MAX_BURST 4
    logic        rst, enable;
    logic [31:0] a_data, b_data, m_data, monitor;
    logic        a_valid, a_ready, b_valid, b_ready, m_valid, m_ready, m_user;

    // Narrow instance: 16 -> 32
    logic        rst16;
    logic [15:0] a16_data, b16_data;
    logic [31:0] m16_data, monitor16;
    logic        a16_valid, a16_ready, b16_valid, b16_ready, m16_valid, m16_ready, m16_user;

    axis_rr_merge #(
        .SAXIS_TDATA_WIDTH(32),
        .MAXIS_TDATA_WIDTH(32),
        .MAX_BURST(4)
    ) dut (
        .a_clk(clk), .a_reset(rst), .enable(enable),
        .S_AXIS_A_tdata(a_data), .S_AXIS_A_tvalid(a_valid), .S_AXIS_A_tready(a_ready),
        .S_AXIS_B_tdata(b_data), .S_AXIS_B_tvalid(b_valid), .S_AXIS_B_tready(b_ready),
        .M_AXIS_tdata(m_data), .M_AXIS_tvalid(m_valid), .M_AXIS_tready(m_ready),
        .M_AXIS_tuser(m_user), .monitor(monitor)
    );

    axis_rr_merge #(
        .SAXIS_TDATA_WIDTH(16),
        .MAXIS_TDATA_WIDTH(32),
        .MAX_BURST(4)
    ) dut16 (
        .a_clk(clk), .a_reset(rst16), .enable(1'b1),
        .S_AXIS_A_tdata(a16_data), .S_AXIS_A_tvalid(a16_valid), .S_AXIS_A_tready(a16_ready),
        .S_AXIS_B_tdata(b16_data), .S_AXIS_B_tvalid(b16_valid), .S_AXIS_B_tready(b16_ready),
        .M_AXIS_tdata(m16_data), .M_AXIS_tvalid(m16_valid), .M_AXIS_tready(m16_ready),
        .M_AXIS_tuser(m16_user), .monitor(monitor16)
    );

    int          checks = 0;
    int          errors = 0;

    logic [32:0] sb[$];        // expected {tuser, tdata}
    bit          order[$];     // tuser of each accepted output beat
    int          out_cyc[$];   // cycle index of each accepted output beat
    int          cyc = 0;
    int          a_left, b_left;
    logic [31:0] a_seq, b_seq;
    logic [15:0] a_sent, b_sent;

    // One clock of traffic: score output beats, record source beats, then
    // advance the source models after the edge.
    task automatic step();
        logic af, bf, of;
        logic [32:0] exp;
        @(negedge clk);
        af = a_valid && a_ready;
        bf = b_valid && b_ready;
        of = m_valid && m_ready;
        if (of) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_beat: got user=%0d data=%h, required no beat", m_user, m_data);
            end else begin
                exp = sb.pop_front();
                if ({m_user, m_data} !== exp) begin
                    errors++;
                    $display("FAIL sb_beat: got user=%0d data=%h, required user=%0d data=%h",
                             m_user, m_data, exp[32], exp[31:0]);
                end
            end
            order.push_back(m_user);
            out_cyc.push_back(cyc);
        end
        if (af) begin sb.push_back({1'b0, a_data}); a_sent++; end
        if (bf) begin sb.push_back({1'b1, b_data}); b_sent++; end
        @(posedge clk); #1;
        cyc++;
        if (af) begin a_left--; a_seq++; a_data = 32'hA000_0000 | a_seq; end
        if (bf) begin b_left--; b_seq++; b_data = 32'hB000_0000 | b_seq; end
        a_valid = (a_left > 0);
        b_valid = (b_left > 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_left = 0; b_left = 0;
        a_seq = 0; b_seq = 0;
        a_data = 32'hA000_0000; b_data = 32'hB000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete(); order.delete(); out_cyc.delete();
        a_sent = '0; b_sent = '0;
    endtask

    task automatic start_sources(input int na, input int nb);
        a_left = na; b_left = nb;
        a_valid = (a_left > 0);
        b_valid = (b_left > 0);
    endtask

    task automatic run_until_done(input string name);
        int n;
        n = 0;
        while ((a_left > 0 || b_left > 0 || sb.size() > 0 || m_valid) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got pending sb=%0d, required drained within 500 cycles", name, sb.size());
        end
    endtask

    task automatic wait_outputs(input string name, input int k);
        for (int n = 0; n < 100 && order.size() < k; n++) step();
        if (order.size() < k) begin
            checks++; errors++;
            $display("FAIL %s_wait: got %0d output beats, required %0d", name, order.size(), k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'h1111_1111; b_data = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h, required 00000000", m_data); end
        checks++; if (m_user !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b, required 0", m_user); end
        checks++; if (monitor !== 32'h0) begin errors++; $display("FAIL reset_monitor: got %h, required 00000000", monitor); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b, required 00", {a_ready, b_ready}); end

        // Reset asserted mid-burst drops the pending beat and blocks sources.
        do_reset();
        start_sources(6, 0);
        wait_outputs("reset_mid", 1);
        rst = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_tready: got %b, required 0", a_ready); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_tvalid: got %b, required 0", m_valid); end
        checks++; if (monitor !== 32'h0) begin errors++; $display("FAIL reset_mid_monitor: got %h, required 00000000", monitor); end
        do_reset();
    endtask

    task automatic test_single_beat();
        do_reset();
        a_data = 32'h1234_5678; a_valid = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_idle_tready: got %b, required 0", a_ready); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_edge1_tvalid: got %b, required 0", m_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_grant_tready: got %b, required 1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_edge2_tvalid: got %b, required 1", m_valid); end
        checks++; if (m_data !== 32'h1234_5678) begin errors++; $display("FAIL single_tdata: got %h, required 12345678", m_data); end
        checks++; if (m_user !== 1'b0) begin errors++; $display("FAIL single_tuser: got %b, required 0", m_user); end
        checks++; if (monitor !== 32'h0000_0001) begin errors++; $display("FAIL single_monitor: got %h, required 00000001", monitor); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b, required 0", m_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        start_sources(12, 12);
        run_until_done("rr");
        checks++;
        if (order.size() != 24) begin errors++; $display("FAIL rr_count: got %0d beats, required 24", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] !== bit'((i / 4) % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got src %0d, required %0d", i, order[i], (i / 4) % 2);
            end
        end
        if (out_cyc.size() == 24) begin
            checks++;
            if (out_cyc[23] - out_cyc[0] != 23) begin
                errors++;
                $display("FAIL rr_no_bubble: got span %0d cycles, required 23", out_cyc[23] - out_cyc[0]);
            end
        end
        checks++; if (monitor !== {16'd12, 16'd12}) begin errors++; $display("FAIL rr_monitor: got %h, required 000c000c", monitor); end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        do_reset();
        start_sources(8, 0);
        wait_outputs("bp", 3);
        m_ready = 1'b0;
        exp = (sb.size() > 0) ? sb[0] : 33'h0;
        checks++; if (sb.size() != 1) begin errors++; $display("FAIL bp_pending: got %0d queued, required 1", sb.size()); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL bp_tready[%0d]: got %b, required 00", i, {a_ready, b_ready}); end
            checks++;
            if (m_valid !== 1'b1 || {m_user, m_data} !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b user=%0d data=%h, required v=1 user=%0d data=%h",
                         i, m_valid, m_user, m_data, exp[32], exp[31:0]);
            end
        end
        m_ready = 1'b1;
        run_until_done("bp");
        checks++; if (order.size() != 8) begin errors++; $display("FAIL bp_count: got %0d beats, required 8", order.size()); end
        checks++; if (monitor !== 32'h0000_0008) begin errors++; $display("FAIL bp_monitor: got %h, required 00000008", monitor); end
    endtask

    task automatic test_a_only();
        do_reset();
        start_sources(10, 0);
        run_until_done("aonly");
        checks++; if (order.size() != 10) begin errors++; $display("FAIL aonly_count: got %0d beats, required 10", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] !== 1'b0) begin errors++; $display("FAIL aonly_src[%0d]: got %0d, required 0", i, order[i]); end
        end
        if (out_cyc.size() == 10) begin
            checks++;
            if (out_cyc[9] - out_cyc[0] != 9) begin
                errors++;
                $display("FAIL aonly_no_bubble: got span %0d cycles, required 9", out_cyc[9] - out_cyc[0]);
            end
        end
        checks++; if (monitor !== 32'h0000_000A) begin errors++; $display("FAIL aonly_monitor: got %h, required 0000000a", monitor); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        start_sources(0, 6);
        wait_outputs("en", 2);
        enable = 1'b0;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL en_tready_drop: got %b, required 0", b_ready); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL en_pending: got %b, required 1", m_valid); end
        step();
        checks++; if (order.size() != 3) begin errors++; $display("FAIL en_drained: got %0d beats, required 3", order.size()); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL en_slot_empty: got %b, required 0", m_valid); end
        enable = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL en_idle: got %b, required 0", b_ready); end
        step();
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL en_regrant: got %b, required 1", b_ready); end
        run_until_done("en");
        checks++; if (order.size() != 6) begin errors++; $display("FAIL en_count: got %0d beats, required 6", order.size()); end
        checks++; if (monitor !== {16'd6, 16'd0}) begin errors++; $display("FAIL en_monitor: got %h, required 00060000", monitor); end
    endtask

    task automatic test_wrap_and_pad();
        int  n;
        bit  first_seen;
        bit  fired;
        rst16 = 1'b1; m16_ready = 1'b1;
        a16_valid = 1'b0; b16_valid = 1'b0; a16_data = 16'hABCD; b16_data = 16'h0;
        @(posedge clk); #1;
        rst16 = 1'b0;
        a16_valid = 1'b1;
        n = 0; first_seen = 0;
        for (int c = 0; c < 70000 && n < 65535; c++) begin
            @(negedge clk);
            if (a16_valid && a16_ready) n++;
            if (m16_valid && !first_seen) begin
                first_seen = 1;
                checks++;
                if (m16_data !== 32'hABCD_0000 || m16_user !== 1'b0) begin
                    errors++;
                    $display("FAIL pad_tdata: got user=%0d data=%h, required user=0 data=abcd0000", m16_user, m16_data);
                end
            end
            @(posedge clk); #1;
            if (n == 65535) a16_valid = 1'b0;
        end
        a16_valid = 1'b0;
        checks++; if (n != 65535) begin errors++; $display("FAIL wrap_fill: got %0d beats, required 65535", n); end
        checks++; if (monitor16 !== 32'h0000_FFFF) begin errors++; $display("FAIL wrap_preset: got %h, required 0000ffff", monitor16); end

        a16_data = 16'h1357; a16_valid = 1'b1;
        fired = 0;
        for (int c = 0; c < 10 && !fired; c++) begin
            @(negedge clk);
            fired = a16_valid && a16_ready;
            @(posedge clk); #1;
        end
        a16_valid = 1'b0;
        checks++; if (!fired) begin errors++; $display("FAIL wrap_beat: got no transfer, required one within 10 cycles"); end
        checks++; if (monitor16 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_monitor: got %h, required 00000000", monitor16); end
        checks++; if (m16_valid !== 1'b1 || m16_data !== 32'h1357_0000) begin
            errors++;
            $display("FAIL wrap_tdata: got v=%b data=%h, required v=1 data=13570000", m16_valid, m16_data);
        end
    endtask

    initial begin
        rst16 = 1'b1; m16_ready = 1'b1; a16_valid = 1'b0; b16_valid = 1'b0;
        a16_data = '0; b16_data = '0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_a_only();
        test_enable_drop();
        test_wrap_and_pad();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_merge.md
AXIS_RR_MERGE -- requirements
Module: axis_rr_merge

Interface
REQ-001 SHALL have parameter SAXIS_TDATA_WIDTH, default 32, giving the source tdata width.
REQ-002 SHALL have parameter MAXIS_TDATA_WIDTH, default 32, giving the output tdata width; MAXIS_TDATA_WIDTH >= SAXIS_TDATA_WIDTH is required.
REQ-003 SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..255).
REQ-004 SHALL have one clock and a synchronous, active-high reset: port a_clk, input, 1 bit, all logic on its rising edge.
REQ-005 SHALL have port a_reset, input, 1 bit, the synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit, which permits new grants when high.
REQ-007 SHALL have ports S_AXIS_A_tdata (input, SAXIS_TDATA_WIDTH), S_AXIS_A_tvalid (input, 1) and S_AXIS_A_tready (output, 1) as source A.
REQ-008 SHALL have ports S_AXIS_B_tdata (input, SAXIS_TDATA_WIDTH), S_AXIS_B_tvalid (input, 1) and S_AXIS_B_tready (output, 1) as source B.
REQ-009 SHALL have ports M_AXIS_tdata (output, MAXIS_TDATA_WIDTH), M_AXIS_tvalid (output, 1) and M_AXIS_tready (input, 1) as the merged output.
REQ-010 SHALL have port M_AXIS_tuser, output, 1 bit, identifying the source of the current output beat (0 = A, 1 = B).
REQ-011 SHALL have port monitor, output, 32 bits, carrying {beats_b[15:0], beats_a[15:0]}.

Function
REQ-012 SHALL implement the states IDLE, GRANT_A and GRANT_B, plus a last_served flag and an 8-bit burst counter.
REQ-013 SHALL hold a single registered output slot; slot_free = !M_AXIS_tvalid || M_AXIS_tready.
REQ-014 SHALL drive S_AXIS_A_tready = (state==GRANT_A) && enable && slot_free; S_AXIS_B_tready is the same with GRANT_B. Both tready outputs are never high in the same cycle.
REQ-015 SHALL count a source transfer when that source's tvalid and tready are both high at a rising edge.
REQ-016 SHALL, on a transfer, load the slot at that edge with tdata = {src_tdata, (MAXIS_TDATA_WIDTH-SAXIS_TDATA_WIDTH) zero LSBs}, tuser = source ID and M_AXIS_tvalid = 1.
REQ-017 SHALL clear M_AXIS_tvalid at an edge where M_AXIS_tready=1 and no new transfer occurs. The slot is never overwritten while M_AXIS_tvalid=1 and M_AXIS_tready=0.
REQ-018 SHALL, while in IDLE with enable=1, move to GRANT_A or GRANT_B at the next edge according to the requesting tvalid. When both request, the source not equal to last_served wins. The burst counter is cleared on any grant.
REQ-019 SHALL give a latency of two edges from tvalid rising in IDLE (with a free slot) to M_AXIS_tvalid high. A sustained burst then runs at 1 beat per cycle.
REQ-020 SHALL, on each transfer in GRANT_x, increment the burst counter and set last_served = x.
REQ-021 SHALL, when the transfer that brings the counter to MAX_BURST occurs:
  - go to GRANT_other if the other tvalid is high;
  - else stay in GRANT_x with the counter cleared.
REQ-022 SHALL, in GRANT_x with src_x tvalid=0, go to GRANT_other (counter cleared) if the other tvalid is high, else go to IDLE.
REQ-023 SHALL, in GRANT_x with tvalid=1 but slot not free, hold the state and the counter. Backpressure never changes the grant.
REQ-024 SHALL, when enable=0, hold both tready outputs low and enter IDLE at the next edge. The output slot continues to drain normally.
REQ-025 SHALL increment beats_a or beats_b (16-bit, wrapping 0xFFFF->0x0000) on each source transfer.
REQ-026 SHALL keep the tdata content unchanged apart from zero-extension of the LSBs; no sign or rounding logic is applied.

Reset
REQ-027 SHALL, while a_reset=1 at an edge, set: state=IDLE, last_served=B (so A wins the first tie), burst counter=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tuser=0, beats_a=beats_b=0.
REQ-028 SHALL, during a reset asserted mid-burst, discard the pending slot beat and hold both tready outputs low in the reset cycle.

Verification
REQ-029 SHALL cover this scenario: after reset, A sends 0x12345678 with M_AXIS_tready=1 -> the beat appears 2 edges later with tuser=0 and monitor=0x00000001.
REQ-030 SHALL cover this scenario: A and B both continuously valid, MAX_BURST=4, tready=1 -> output pattern AAAABBBBAAAA..., no idle cycles after the first beat.
REQ-031 SHALL cover this scenario: M_AXIS_tready held 0 for 5 cycles mid-burst -> the slot data is stable, both tready outputs are low, and no beat is lost or duplicated (counts match the source).
REQ-032 SHALL cover this scenario: A valid only, B idle, 10 beats -> continuous A stream with the counter re-cleared every 4 beats and no bubble.
REQ-033 SHALL cover this scenario: enable dropped during GRANT_B -> tready goes low immediately, state is IDLE next edge, the pending output beat still drains.
REQ-034 SHALL cover this scenario: SAXIS=16, MAXIS=32, input 0xABCD -> M_AXIS_tdata=0xABCD0000; beats_a preset to 0xFFFF via traffic -> the next beat wraps it to 0x0000.
